// File: rtl/prng_lfsr_stream.sv
// ---------------------------------------------------------------------------
// prng_lfsr_stream
//
// Parametrised LFSR pseudo-random word generator. The LFSR shifts left once
// per enabled cycle, using either Fibonacci (parity of tapped bits fed into
// the LSB) or Galois (polynomial XORed in when the MSB falls out) feedback.
// After OUT_W advances the low OUT_W bits of the state are presented as one
// word over a valid/ready handshake. While a word is waiting, the LFSR is
// frozen, so no state is wasted under backpressure. A seed can be loaded at
// any time, and an all-zero seed or state is replaced by SEED_DEFAULT so the
// generator can never lock up.
//
// Ports:
//   clk         clock
//   rst_n       asynchronous, active-low reset
//   en          advance enable; state frozen when low
//   mode        feedback select: 0 = Fibonacci, 1 = Galois
//   seed_valid  one-cycle seed load strobe
//   seed_in     seed value (STATE_W bits)
//   out_ready   consumer accepts the current word
//   out_valid   a word is available on out_data
//   out_data    random word (OUT_W bits)
//   seed_fixup  sticky flag: a zero seed or zero state was replaced
//   state_o     current LFSR state (debug)
// ---------------------------------------------------------------------------
module prng_lfsr_stream #(
  parameter int                 STATE_W      = 16,
  parameter int                 OUT_W        = 8,
  parameter logic [STATE_W-1:0] FIB_TAPS     = 16'hD008,
  parameter logic [STATE_W-1:0] GAL_POLY     = 16'h002D,
  parameter logic [STATE_W-1:0] SEED_DEFAULT = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic               seed_valid,
  input  logic [STATE_W-1:0] seed_in,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [OUT_W-1:0]   out_data,
  output logic               seed_fixup,
  output logic [STATE_W-1:0] state_o
);

  // A zero default seed would defeat the lock-up protection, and the word
  // is cut from the state, so it cannot be wider than the state.
  if (OUT_W > STATE_W || OUT_W < 1 || STATE_W < 4 || STATE_W > 32 ||
      SEED_DEFAULT == '0) begin : gen_param_check
    $error("prng_lfsr_stream: illegal parameter combination");
  end

  // The counter must be at least one bit wide even when OUT_W is 1.
  localparam int CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_W - 1);

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_VALID = 1'b1
  } fsm_e;

  fsm_e               fsm_q, fsm_d;
  logic [STATE_W-1:0] lfsr_q, lfsr_d;
  logic [STATE_W-1:0] lfsrNext;
  logic [STATE_W-1:0] fibNext;
  logic [STATE_W-1:0] galNext;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               outValid_q, outValid_d;
  logic [OUT_W-1:0]   outData_q, outData_d;
  logic               seedFixup_q, seedFixup_d;

  // Both feedback flavours are computed every cycle and mode picks one, so a
  // mode change simply applies to whichever advance comes next.
  always_comb begin
    fibNext  = {lfsr_q[STATE_W-2:0], ^(lfsr_q & FIB_TAPS)};
    galNext  = (lfsr_q << 1) ^ (lfsr_q[STATE_W-1] ? GAL_POLY : '0);
    lfsrNext = mode ? galNext : fibNext;
  end

  // Next-state logic. A seed strobe overrides everything else, including a
  // handshake completing in the same cycle, and throws away any pending
  // word. In FILL, a zero state is repaired instead of advanced (the repair
  // does not count towards the word). VALID holds the word until accepted.
  always_comb begin
    fsm_d       = fsm_q;
    lfsr_d      = lfsr_q;
    cnt_d       = cnt_q;
    outValid_d  = outValid_q;
    outData_d   = outData_q;
    seedFixup_d = seedFixup_q;

    if (seed_valid) begin
      if (seed_in == '0) begin
        lfsr_d      = SEED_DEFAULT;
        seedFixup_d = 1'b1;
      end else begin
        lfsr_d      = seed_in;
        seedFixup_d = 1'b0;
      end
      cnt_d      = '0;
      fsm_d      = ST_FILL;
      outValid_d = 1'b0;
    end else begin
      case (fsm_q)
        ST_FILL: begin
          if (en) begin
            if (lfsr_q == '0) begin
              lfsr_d      = SEED_DEFAULT;
              seedFixup_d = 1'b1;
            end else begin
              lfsr_d = lfsrNext;
              if (cnt_q == CNT_LAST) begin
                outData_d  = lfsrNext[OUT_W-1:0];
                outValid_d = 1'b1;
                cnt_d      = '0;
                fsm_d      = ST_VALID;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
          end
        end
        ST_VALID: begin
          if (outValid_q && out_ready) begin
            outValid_d = 1'b0;
            fsm_d      = ST_FILL;
          end
        end
        default: begin
          fsm_d = ST_FILL;
        end
      endcase
    end
  end

  // State register. Reset restarts from the default seed with no word
  // pending and the fix-up flag cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= ST_FILL;
      lfsr_q      <= SEED_DEFAULT;
      cnt_q       <= '0;
      outValid_q  <= 1'b0;
      outData_q   <= '0;
      seedFixup_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      lfsr_q      <= lfsr_d;
      cnt_q       <= cnt_d;
      outValid_q  <= outValid_d;
      outData_q   <= outData_d;
      seedFixup_q <= seedFixup_d;
    end
  end

  assign out_valid  = outValid_q;
  assign out_data   = outData_q;
  assign seed_fixup = seedFixup_q;
  assign state_o    = lfsr_q;

endmodule

// File: tb/tb_prng_lfsr_stream.sv
// ---------------------------------------------------------------------------
// tb_prng_lfsr_stream
//
// Directed bench for prng_lfsr_stream with default parameters (16-bit state,
// 8-bit words). Expected values are hand-computed LFSR sequences. Inputs are
// driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_prng_lfsr_stream;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        mode;
  logic        seed_valid;
  logic [15:0] seed_in;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        seed_fixup;
  logic [15:0] state_o;

  int testsRun;
  int testsFailed;

  typedef struct {
    logic [15:0] seed;
    logic        mode;
    logic [15:0] loadState;
    logic [15:0] expState;
    logic [7:0]  expData;
    logic        expFixup;
  } vec_t;

  vec_t        vecs[6];
  logic [15:0] fibSeq[8];

  prng_lfsr_stream dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mode       (mode),
    .seed_valid (seed_valid),
    .seed_in    (seed_in),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .seed_fixup (seed_fixup),
    .state_o    (state_o)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something hangs despite the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Strobe a seed for one cycle; returns at the falling edge after the load.
  task automatic applyStimulus(input logic [15:0] seed, input logic m);
    mode       = m;
    seed_in    = seed;
    seed_valid = 1'b1;
    @(negedge clk);
    seed_valid = 1'b0;
  endtask

  // Count falling edges until out_valid is seen, bounded.
  task automatic waitValid(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  initial begin
    int          cyc;
    logic [7:0]  holdData;
    logic [15:0] holdState;
    logic [15:0] prevState;

    testsRun    = 0;
    testsFailed = 0;

    fibSeq = '{16'h0002, 16'h0004, 16'h0008, 16'h0011,
               16'h0022, 16'h0044, 16'h0088, 16'h0111};

    vecs[0] = '{16'h0001, 1'b0, 16'h0001, 16'h0111, 8'h11, 1'b0};
    vecs[1] = '{16'h8000, 1'b1, 16'h8000, 16'h1680, 8'h80, 1'b0};
    vecs[2] = '{16'h0000, 1'b0, 16'hACE1, 16'hE18A, 8'h8A, 1'b1};
    vecs[3] = '{16'h0001, 1'b1, 16'h0001, 16'h0100, 8'h00, 1'b0};
    vecs[4] = '{16'h8000, 1'b0, 16'h8000, 16'h0088, 8'h88, 1'b0};
    vecs[5] = '{16'hFFFF, 1'b1, 16'hFFFF, 16'hE41B, 8'h1B, 1'b0};

    rst_n      = 1'b0;
    en         = 1'b0;
    mode       = 1'b0;
    seed_valid = 1'b0;
    seed_in    = '0;
    out_ready  = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset state_o", 32'(state_o), 32'h0000ACE1);
    checkOutput("reset out_valid", 32'(out_valid), 32'h0);
    checkOutput("reset out_data", 32'(out_data), 32'h0);
    checkOutput("reset seed_fixup", 32'(seed_fixup), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fibonacci word, step by step from seed 0x0001
    en = 1'b1;
    applyStimulus(16'h0001, 1'b0);
    checkOutput("fib load state", 32'(state_o), 32'h0001);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput($sformatf("fib step %0d state", i), 32'(state_o), 32'(fibSeq[i]));
      checkOutput($sformatf("fib step %0d valid", i), 32'(out_valid), (i == 7) ? 32'h1 : 32'h0);
    end
    checkOutput("fib word data", 32'(out_data), 32'h11);

    // Backpressure: everything frozen while the word waits
    holdData  = out_data;
    holdState = state_o;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("stall data", 32'(out_data), 32'(holdData));
      checkOutput("stall state", 32'(state_o), 32'(holdState));
      checkOutput("stall valid", 32'(out_valid), 32'h1);
    end

    // Throughput: a new word every 9 cycles once out_ready is held high
    out_ready = 1'b1;
    for (int w = 0; w < 2; w++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!out_valid && cyc < 40);
      checkOutput($sformatf("word %0d interval", w), 32'(cyc), 32'd9);
      if (w == 0) begin
        checkOutput("stream word data", 32'(out_data), 32'h1A);
        checkOutput("stream word state", 32'(state_o), 32'h111A);
      end
    end
    out_ready = 1'b0;

    // Table-driven words; each seed load lands while a word is pending
    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].seed, vecs[v].mode);
      checkOutput($sformatf("vec %0d valid dropped", v), 32'(out_valid), 32'h0);
      checkOutput($sformatf("vec %0d load state", v), 32'(state_o), 32'(vecs[v].loadState));
      checkOutput($sformatf("vec %0d load fixup", v), 32'(seed_fixup), 32'(vecs[v].expFixup));
      waitValid(cyc);
      checkOutput($sformatf("vec %0d latency", v), 32'(cyc), 32'd8);
      checkOutput($sformatf("vec %0d state", v), 32'(state_o), 32'(vecs[v].expState));
      checkOutput($sformatf("vec %0d data", v), 32'(out_data), 32'(vecs[v].expData));
      checkOutput($sformatf("vec %0d fixup", v), 32'(seed_fixup), 32'(vecs[v].expFixup));
    end

    // Seed strobe coincident with an accepted word: the seed wins
    out_ready = 1'b1;
    applyStimulus(16'h8000, 1'b0);
    out_ready = 1'b0;
    checkOutput("seed+ready valid", 32'(out_valid), 32'h0);
    checkOutput("seed+ready state", 32'(state_o), 32'h8000);
    waitValid(cyc);
    checkOutput("seed+ready latency", 32'(cyc), 32'd8);
    checkOutput("seed+ready state", 32'(state_o), 32'h0088);
    checkOutput("seed+ready data", 32'(out_data), 32'h88);

    // Enable toggled every cycle: same sequence, half the rate
    applyStimulus(16'h0001, 1'b0);
    prevState = state_o;
    for (int k = 1; k <= 16; k++) begin
      en = (k % 2 == 0);
      @(negedge clk);
      if (k % 2 == 0) begin
        checkOutput($sformatf("gated cycle %0d state", k), 32'(state_o), 32'(fibSeq[k/2-1]));
      end else begin
        checkOutput($sformatf("gated cycle %0d hold", k), 32'(state_o), 32'(prevState));
      end
      checkOutput($sformatf("gated cycle %0d valid", k), 32'(out_valid), (k == 16) ? 32'h1 : 32'h0);
      prevState = state_o;
    end
    checkOutput("gated word data", 32'(out_data), 32'h11);

    // Asynchronous reset in the middle of FILL with the fix-up flag set
    en = 1'b1;
    applyStimulus(16'h0000, 1'b0);
    for (int i = 0; i < 3; i++) @(negedge clk);
    checkOutput("pre-reset fixup", 32'(seed_fixup), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset state", 32'(state_o), 32'h0000ACE1);
    checkOutput("async reset valid", 32'(out_valid), 32'h0);
    checkOutput("async reset data", 32'(out_data), 32'h0);
    checkOutput("async reset fixup", 32'(seed_fixup), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
